// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline. It adds a multi-cycle divider
// stall FSM, exception flush, HI/LO forwarding and r0-safe load-use/branch stall detection.
module hazard_ctrl_mc #(
  parameter int REG_W           = 5,
  parameter int DIV_CYCLES      = 32,
  parameter int BRANCH_STALL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic             hilowriteM,
  input  logic             hilowriteW,
  input  logic             divstartE,
  input  logic             exceptM,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardhiloE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             div_busy,
  output logic             div_done
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  // The start cycle is spent in IDLE, so the run phase lasts DIV_CYCLES-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_RUN  = 2'd1,
    S_DIV_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  logic rsE_nz, rtE_nz, rsD_nz, rtD_nz;
  logic wrE_nz, wrM_nz;
  logic lwstall, branchstall, hazard, div_start;

  assign rsE_nz = (rsE != '0);
  assign rtE_nz = (rtE != '0);
  assign rsD_nz = (rsD != '0);
  assign rtD_nz = (rtD != '0);
  assign wrE_nz = (writeregE != '0);
  assign wrM_nz = (writeregM != '0);

  always_comb begin
    forwardAE = 2'b00;
    if (rsE_nz && (rsE == writeregM) && regwriteM)      forwardAE = 2'b10;
    else if (rsE_nz && (rsE == writeregW) && regwriteW) forwardAE = 2'b01;
  end

  always_comb begin
    forwardBE = 2'b00;
    if (rtE_nz && (rtE == writeregM) && regwriteM)      forwardBE = 2'b10;
    else if (rtE_nz && (rtE == writeregW) && regwriteW) forwardBE = 2'b01;
  end

  assign forwardAD = rsD_nz && (rsD == writeregM) && regwriteM;
  assign forwardBD = rtD_nz && (rtD == writeregM) && regwriteM;

  always_comb begin
    forwardhiloE = 2'b00;
    if (hilowriteM)      forwardhiloE = 2'b10;
    else if (hilowriteW) forwardhiloE = 2'b01;
  end

  assign lwstall = memtoregE && rtE_nz && ((rsD == rtE) || (rtD == rtE));

  assign branchstall = (BRANCH_STALL_EN != 0) && branchD &&
                       ((regwriteE && wrE_nz && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && wrM_nz && ((writeregM == rsD) || (writeregM == rtD))));

  assign hazard    = lwstall || branchstall;
  assign div_start = (state_q == S_IDLE) && divstartE;

  // run_q/done_q are registered decodes of the state, kept alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (exceptM) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (divstartE) begin
            state_q <= S_DIV_RUN;
            cnt_q   <= CNT_LOAD;
            run_q   <= 1'b1;
          end
        end
        S_DIV_RUN: begin
          if (cnt_q == '0) begin
            state_q <= S_DIV_DONE;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          run_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Priority: rst > exceptM > divider > load-use/branch hazards.
  always_comb begin
    stallF   = 1'b0;
    stallD   = 1'b0;
    stallE   = 1'b0;
    flushD   = 1'b0;
    flushE   = 1'b0;
    flushM   = 1'b0;
    div_busy = 1'b0;
    div_done = 1'b0;
    if (rst) begin
      stallF = 1'b0;
    end else if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (run_q) begin
      stallF   = 1'b1;
      stallD   = 1'b1;
      stallE   = 1'b1;
      flushM   = 1'b1;
      div_busy = 1'b1;
    end else if (div_start) begin
      // The div is held in E from its first cycle; flushing E here would kill it.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else begin
      stallF   = hazard;
      stallD   = hazard;
      flushE   = hazard;
      div_done = done_q;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: three instances (4-cycle divider, 32-cycle divider,
// branch stall disabled) share inputs; directed vectors queue expectations for a monitor.
module tb_hazard_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM, branchD;
  logic [4:0] writeregE, writeregM, writeregW;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic       hilowriteM, hilowriteW, divstartE, exceptM;

  logic [1:0] fae [3];
  logic [1:0] fbe [3];
  logic [1:0] fhl [3];
  logic       fad [3];
  logic       fbd [3];
  logic       sF [3];
  logic       sD [3];
  logic       sE [3];
  logic       fD [3];
  logic       fE [3];
  logic       fM [3];
  logic       busy [3];
  logic       done [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] fwd;
    logic [7:0] ctl;
    string      name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_ctrl_mc #(.REG_W(5), .DIV_CYCLES(4), .BRANCH_STALL_EN(1)) dut0 (
    .clk(clk), .rst(rst), .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .hilowriteM(hilowriteM), .hilowriteW(hilowriteW),
    .divstartE(divstartE), .exceptM(exceptM),
    .forwardAE(fae[0]), .forwardBE(fbe[0]), .forwardAD(fad[0]), .forwardBD(fbd[0]),
    .forwardhiloE(fhl[0]), .stallF(sF[0]), .stallD(sD[0]), .stallE(sE[0]),
    .flushD(fD[0]), .flushE(fE[0]), .flushM(fM[0]), .div_busy(busy[0]), .div_done(done[0]));

  hazard_ctrl_mc #(.REG_W(5), .DIV_CYCLES(32), .BRANCH_STALL_EN(1)) dut32 (
    .clk(clk), .rst(rst), .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .hilowriteM(hilowriteM), .hilowriteW(hilowriteW),
    .divstartE(divstartE), .exceptM(exceptM),
    .forwardAE(fae[1]), .forwardBE(fbe[1]), .forwardAD(fad[1]), .forwardBD(fbd[1]),
    .forwardhiloE(fhl[1]), .stallF(sF[1]), .stallD(sD[1]), .stallE(sE[1]),
    .flushD(fD[1]), .flushE(fE[1]), .flushM(fM[1]), .div_busy(busy[1]), .div_done(done[1]));

  hazard_ctrl_mc #(.REG_W(5), .DIV_CYCLES(4), .BRANCH_STALL_EN(0)) dutnb (
    .clk(clk), .rst(rst), .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .hilowriteM(hilowriteM), .hilowriteW(hilowriteW),
    .divstartE(divstartE), .exceptM(exceptM),
    .forwardAE(fae[2]), .forwardBE(fbe[2]), .forwardAD(fad[2]), .forwardBD(fbd[2]),
    .forwardhiloE(fhl[2]), .stallF(sF[2]), .stallD(sD[2]), .stallE(sE[2]),
    .flushD(fD[2]), .flushE(fE[2]), .flushM(fM[2]), .div_busy(busy[2]), .div_done(done[2]));

  // fwd = {forwardAE, forwardBE, forwardAD, forwardBD, forwardhiloE}
  // ctl = {stallF, stallD, stallE, flushD, flushE, flushM, div_busy, div_done}
  task automatic expect_now(input int idx, input string name, input logic [7:0] fwd,
                            input logic [7:0] ctl);
    exp_t e;
    e.cyc  = cyc;
    e.idx  = idx;
    e.fwd  = fwd;
    e.ctl  = ctl;
    e.name = name;
    q.push_back(e);
  endtask

  exp_t       e_m;
  logic [7:0] act_fwd, act_ctl;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_m = q.pop_front();
      checks++;
      act_fwd = {fae[e_m.idx], fbe[e_m.idx], fad[e_m.idx], fbd[e_m.idx], fhl[e_m.idx]};
      act_ctl = {sF[e_m.idx], sD[e_m.idx], sE[e_m.idx], fD[e_m.idx], fE[e_m.idx],
                 fM[e_m.idx], busy[e_m.idx], done[e_m.idx]};
      if (e_m.cyc != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now cycle %0d)",
                 e_m.name, e_m.cyc, cyc);
      end else if (act_fwd !== e_m.fwd || act_ctl !== e_m.ctl) begin
        failures++;
        $display("FAIL %s (inst %0d, cycle %0d): got fwd=%b ctl=%b, expected fwd=%b ctl=%b",
                 e_m.name, e_m.idx, cyc, act_fwd, act_ctl, e_m.fwd, e_m.ctl);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; branchD = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    hilowriteM = 0; hilowriteW = 0; divstartE = 0; exceptM = 0;
  endtask

  task automatic do_reset();
    step(); clr(); rst = 1;
    step(); clr(); rst = 0;
  endtask

  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_HAZ   = 8'b1100_1000;
  localparam logic [7:0] C_START = 8'b1110_0100;
  localparam logic [7:0] C_RUN   = 8'b1110_0110;
  localparam logic [7:0] C_DONE  = 8'b0000_0001;
  localparam logic [7:0] C_EXC   = 8'b0001_1100;

  initial begin
    clr();
    rst = 1;
    step(); clr(); rst = 1;
    for (int i = 0; i < 3; i++) expect_now(i, "reset_state", 8'h00, C_IDLE);
    step(); clr(); rst = 1; exceptM = 1;
    for (int i = 0; i < 3; i++) expect_now(i, "rst_over_except", 8'h00, C_IDLE);
    step(); clr(); rst = 0;
    expect_now(0, "idle_after_reset", 8'h00, C_IDLE);

    // Forwarding
    step(); clr(); rsE = 5; rtE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    expect_now(0, "fwd_m_priority", 8'b1010_0000, C_IDLE);
    step(); clr(); rsE = 0; rtE = 5; writeregM = 0; regwriteM = 1; writeregW = 5; regwriteW = 1;
    expect_now(0, "fwd_r0_and_w", 8'b0001_0000, C_IDLE);
    step(); clr(); rsE = 7; rtE = 7; writeregM = 7; regwriteM = 0; writeregW = 7; regwriteW = 1;
    expect_now(0, "fwd_w_no_regwriteM", 8'b0101_0000, C_IDLE);
    step(); clr(); rsD = 4; rtD = 9; writeregM = 4; regwriteM = 1;
    expect_now(0, "fwd_ad", 8'b0000_1000, C_IDLE);
    step(); clr(); rtD = 9; writeregM = 9; regwriteM = 1;
    expect_now(0, "fwd_bd", 8'b0000_0100, C_IDLE);
    step(); clr(); writeregM = 0; regwriteM = 1; regwriteW = 1;
    expect_now(0, "fwd_r0_none", 8'b0000_0000, C_IDLE);
    step(); clr(); hilowriteM = 1; hilowriteW = 1;
    expect_now(0, "hilo_m_priority", 8'b0000_0010, C_IDLE);
    step(); clr(); hilowriteW = 1;
    expect_now(0, "hilo_w", 8'b0000_0001, C_IDLE);

    // Load-use
    step(); clr(); memtoregE = 1; rtE = 8; rsD = 8;
    expect_now(0, "lwstall_rs", 8'h00, C_HAZ);
    expect_now(2, "lwstall_rs_nb", 8'h00, C_HAZ);
    step(); clr(); memtoregE = 1; rtE = 0; rsD = 8;
    expect_now(0, "lwstall_r0", 8'h00, C_IDLE);
    step(); clr(); memtoregE = 1; rtE = 6; rtD = 6; rsD = 1;
    expect_now(0, "lwstall_rt", 8'h00, C_HAZ);
    step(); clr(); rtE = 6; rtD = 6;
    expect_now(0, "no_load_no_stall", 8'h00, C_IDLE);

    // Branch stall
    step(); clr(); branchD = 1; regwriteE = 1; writeregE = 3; rsD = 3;
    expect_now(0, "branch_e_en", 8'h00, C_HAZ);
    expect_now(2, "branch_e_dis", 8'h00, C_IDLE);
    step(); clr(); branchD = 1; memtoregM = 1; writeregM = 2; rtD = 2;
    expect_now(0, "branch_m_en", 8'h00, C_HAZ);
    expect_now(2, "branch_m_dis", 8'h00, C_IDLE);
    step(); clr(); branchD = 1; regwriteE = 1; writeregE = 0;
    expect_now(0, "branch_r0", 8'h00, C_IDLE);
    step(); clr(); regwriteE = 1; writeregE = 3; rsD = 3;
    expect_now(0, "no_branch", 8'h00, C_IDLE);

    // 4-cycle divide, lwstall ignored while running, restart refused in DIV_DONE
    do_reset();
    step(); clr(); divstartE = 1;
    expect_now(0, "div4_start", 8'h00, C_START);
    for (int i = 1; i <= 3; i++) begin
      step(); clr();
      if (i == 2) begin memtoregE = 1; rtE = 8; rsD = 8; end
      expect_now(0, "div4_run", 8'h00, C_RUN);
    end
    step(); clr(); divstartE = 1;
    expect_now(0, "div4_done", 8'h00, C_DONE);
    step(); clr();
    expect_now(0, "div4_idle", 8'h00, C_IDLE);

    // 32-cycle divide aborted by an exception on the 10th run cycle
    do_reset();
    step(); clr(); divstartE = 1;
    expect_now(1, "div32_start", 8'h00, C_START);
    for (int i = 1; i <= 9; i++) begin
      step(); clr();
      expect_now(1, "div32_run", 8'h00, C_RUN);
    end
    step(); clr(); exceptM = 1;
    expect_now(1, "except_in_run", 8'h00, C_EXC);
    step(); clr();
    expect_now(1, "except_to_idle", 8'h00, C_IDLE);

    // Full 32-cycle divide
    step(); clr(); divstartE = 1;
    expect_now(1, "div32_full_start", 8'h00, C_START);
    for (int i = 1; i <= 31; i++) begin
      step(); clr();
      expect_now(1, "div32_full_run", 8'h00, C_RUN);
    end
    step(); clr();
    expect_now(1, "div32_full_done", 8'h00, C_DONE);
    step(); clr();
    expect_now(1, "div32_full_idle", 8'h00, C_IDLE);

    // Exception blocks a start
    step(); clr(); divstartE = 1; exceptM = 1;
    expect_now(1, "except_blocks_start", 8'h00, C_EXC);
    step(); clr();
    expect_now(1, "no_start_after_except", 8'h00, C_IDLE);

    // Reset in the middle of a run
    do_reset();
    step(); clr(); divstartE = 1;
    expect_now(0, "rst_test_start", 8'h00, C_START);
    step(); clr();
    expect_now(0, "rst_test_run", 8'h00, C_RUN);
    step(); clr(); rst = 1; hilowriteM = 1; hilowriteW = 1;
    expect_now(0, "rst_mid_run", 8'b0000_0010, C_IDLE);
    step(); clr(); rst = 0;
    expect_now(0, "after_rst_idle", 8'h00, C_IDLE);

    repeat (3) step();
    while (q.size() > 0) begin
      e_m = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: expectation never checked", e_m.name);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline. It replaces the purely combinational hazard logic with the following additions:
- A sequential multi-cycle divider stall FSM.
- Exception-driven pipeline flush.
- HI/LO forwarding from both M and W.
- r0-safe load-use detection.
- Optional decode-stage branch stall.
It sits beside the datapath and drives all stall, flush and forward selects.

Parameters:
REG_W, 5, register-address width.
DIV_CYCLES, 32, cycles the divider needs after start (>=2).
BRANCH_STALL_EN, 1, 1 = stall decode-stage branches on E/M producer hazards; 0 = never branch-stall.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
regwriteE, regwriteM, regwriteW  in  1 each  register write enable per stage
memtoregE, memtoregM  in  1 each  load in stage
branchD  in  1  branch in decode
writeregE, writeregM, writeregW  in  REG_W each  destination register per stage
rsD, rtD, rsE, rtE  in  REG_W each  source registers
hilowriteM, hilowriteW  in  1 each  HI/LO write in stage
divstartE  in  1  divide instruction present in E
exceptM  in  1  exception taken in M
forwardAE, forwardBE  out  2 each  10 = from M, 01 = from W, 00 = regfile
forwardAD, forwardBD  out  1 each  decode forward from M
forwardhiloE  out  2  10 = M, 01 = W, 00 = HI/LO register
stallF, stallD, stallE  out  1 each  hold stage register
flushD, flushE, flushM  out  1 each  clear stage register to bubble
div_busy  out  1  divider running
div_done  out  1  one-cycle pulse, quotient valid

Behaviour:

Reset:
- Clocked rst drives the FSM to IDLE and the counter to 0.
- While rst=1, all stall/flush outputs, div_busy and div_done are 0.
- Forward selects stay combinational on their inputs.

Forwarding (combinational):
- forwardAE = 10 if rsE!=0 & rsE==writeregM & regwriteM; else 01 if rsE!=0 & rsE==writeregW & regwriteW; else 00.
- forwardBE: same rule using rtE.
- forwardAD = rsD!=0 & rsD==writeregM & regwriteM.
- forwardBD: same rule using rtD.
- forwardhiloE = 10 if hilowriteM, else 01 if hilowriteW, else 00. M has priority.

Hazard terms:
- lwstall = memtoregE & rtE!=0 & (rsD==rtE | rtD==rtE).
- branchstall = BRANCH_STALL_EN & branchD & [(regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD)) | (memtoregM & writeregM!=0 & (writeregM==rsD | writeregM==rtD))].

FSM states: IDLE, DIV_RUN, DIV_DONE. Counter width is clog2(DIV_CYCLES).
- IDLE:
  - divstartE & !exceptM -> DIV_RUN, counter loaded with DIV_CYCLES-2.
  - Outputs: stallF = stallD = flushE = lwstall | branchstall; stallE = 0; flushM = 0.
  - The start cycle itself already asserts stallF, stallD, stallE and flushM (div held in E).
- DIV_RUN:
  - Outputs: div_busy = 1; stallF = stallD = stallE = 1; flushE = 0; flushM = 1 (bubbles into M).
  - lwstall and branchstall are ignored.
  - Counter decrements each cycle; at 0 -> DIV_DONE.
- DIV_DONE (one cycle):
  - Outputs: div_done = 1; div_busy = 0; stalls released except lwstall/branchstall terms.
  - The div instruction advances to M.
  - Next state is IDLE.
  - A new divstartE is not accepted in this state. It is accepted in IDLE the next cycle.

Total divider stall: the div occupies E for exactly DIV_CYCLES cycles including the start cycle.

Exception priority:
- exceptM=1 in any state: flushD = flushE = flushM = 1; all stalls = 0; div_busy = div_done = 0.
- Next state is IDLE (an in-flight divide is aborted).
- Priority order: rst > exceptM > divider > lwstall/branchstall.

Test Plan:
1. rsE=rtE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE = forwardBE = 10. Same stimulus with writeregM=0, rsE=0 -> forwardAE = 00.
2. memtoregE=1, rtE=8, rsD=8 -> stallF = stallD = flushE = 1 for one cycle. Same with rtE=0 -> no stall.
3. DIV_CYCLES=4, divstartE pulse -> stallE=1 and flushM=1 for 4 cycles (start cycle plus 3 cycles with div_busy=1), then div_done=1 for 1 cycle, then IDLE.
4. DIV_CYCLES=32, exceptM=1 on the 10th run cycle -> that cycle flushD = flushE = flushM = 1 and stalls = 0; next cycle div_busy = 0, FSM in IDLE.
5. branchD=1, regwriteE=1, writeregE=rsD=3 -> stallD=1 with BRANCH_STALL_EN=1; stallD=0 with BRANCH_STALL_EN=0.
6. rst asserted mid-DIV_RUN -> next cycle div_busy=0 and all stall/flush outputs 0. hilowriteM=hilowriteW=1 -> forwardhiloE=10.
